stage_if: RTL and testbench

STAGE_IF -- requirements
Module: stage_if

---
 rtl/rvcpu_pkg.sv | 26 ++
 rtl/fetch_queue.sv | 72 +++++++
 rtl/stage_if.sv | 130 +++++++++++++
 tb/tb_stage_if.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvcpu_pkg.sv
// Shared RV CPU types used by the fetch stage and its queue.
package rvcpu;

   typedef logic [31:0] pc_t;
   typedef logic [31:0] opcode_t;

   typedef struct packed {
      pc_t     pc;
      opcode_t opcode;
      logic    fault;
   } stage_if_t;

   localparam opcode_t NopOpcode = 32'h0000_0013;

   localparam int unsigned IfQueueDepth   = 3;
   localparam int unsigned IfMaxInflight  = 2;

   function automatic pc_t align_pc(input pc_t pc);
      return pc & ~pc_t'(3);
   endfunction

   function automatic logic [1:0] wrap3_inc(input logic [1:0] ptr);
      return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Three-entry in-order word queue between instruction memory and decode.
module fetch_queue
   import rvcpu::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       push,
   input  stage_if_t  push_data,
   input  logic       pop,
   output stage_if_t  head,
   output logic       full,
   output logic       empty,
   output logic [1:0] count
);

   stage_if_t  mem_q [IfQueueDepth];
   stage_if_t  mem_d [IfQueueDepth];
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [1:0] cnt_q, cnt_d;
   logic       do_push, do_pop;

   assign full  = (cnt_q == 2'd3);
   assign empty = (cnt_q == 2'd0);
   assign count = cnt_q;
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wrap3_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = wrap3_inc(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < IfQueueDepth; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/stage_if.sv
// Instruction fetch stage: issues sequential fetches, tracks up to two in
// flight by epoch, and buffers returned words for decode.
module stage_if
   import rvcpu::*;
#(
   parameter pc_t ResetPC = 32'h8000_0000
) (
   input  logic      clk,
   input  logic      rst,
   output logic      imem_req_valid,
   input  logic      imem_req_ready,
   output pc_t       imem_req_addr,
   input  logic      imem_rsp_valid,
   input  opcode_t   imem_rsp_data,
   input  logic      imem_rsp_err,
   input  logic      redirect_valid,
   input  pc_t       redirect_pc,
   input  logic      stall,
   output logic      out_valid,
   output stage_if_t out
);

   pc_t        pc_q, pc_d;
   logic       epoch_q, epoch_d;

   pc_t        trk_pc_q [IfMaxInflight];
   pc_t        trk_pc_d [IfMaxInflight];
   logic       trk_ep_q [IfMaxInflight];
   logic       trk_ep_d [IfMaxInflight];
   logic       trk_wr_q, trk_wr_d;
   logic       trk_rd_q, trk_rd_d;
   logic [1:0] trk_cnt_q, trk_cnt_d;

   logic       req_fire;
   logic       rsp_take;
   logic       rsp_live;
   logic [2:0] occupancy;
   stage_if_t  push_data;
   stage_if_t  q_head;
   logic       q_full, q_empty;
   logic [1:0] q_cnt;
   logic       q_pop;

   always_comb begin
      occupancy      = {1'b0, trk_cnt_q} + {1'b0, q_cnt};
      imem_req_valid = !rst && !redirect_valid && !q_full
                       && (trk_cnt_q < 2'd2) && (occupancy < 3'd3);
      imem_req_addr  = pc_q;
      req_fire       = imem_req_valid && imem_req_ready;

      // Any response frees a tracker slot; only current-epoch ones are kept.
      rsp_take = !rst && imem_rsp_valid && (trk_cnt_q != 2'd0);
      rsp_live = rsp_take && !redirect_valid && (trk_ep_q[trk_rd_q] == epoch_q);

      push_data.pc     = trk_pc_q[trk_rd_q];
      push_data.fault  = imem_rsp_err;
      push_data.opcode = imem_rsp_err ? NopOpcode : imem_rsp_data;

      out_valid = !rst && !redirect_valid && !q_empty;
      out       = rst ? '0 : q_head;
      q_pop     = out_valid && !stall;
   end

   always_comb begin
      pc_d      = pc_q;
      epoch_d   = epoch_q;
      trk_pc_d  = trk_pc_q;
      trk_ep_d  = trk_ep_q;
      trk_wr_d  = trk_wr_q;
      trk_rd_d  = trk_rd_q;
      trk_cnt_d = trk_cnt_q;

      if (redirect_valid) begin
         pc_d    = align_pc(redirect_pc);
         epoch_d = !epoch_q;
      end else if (req_fire) begin
         pc_d = pc_q + 32'd4;
      end

      if (req_fire) begin
         trk_pc_d[trk_wr_q] = pc_q;
         trk_ep_d[trk_wr_q] = epoch_q;
         trk_wr_d           = !trk_wr_q;
      end
      if (rsp_take) begin
         trk_rd_d = !trk_rd_q;
      end
      case ({req_fire, rsp_take})
         2'b10:   trk_cnt_d = trk_cnt_q + 2'd1;
         2'b01:   trk_cnt_d = trk_cnt_q - 2'd1;
         default: trk_cnt_d = trk_cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= align_pc(ResetPC);
         epoch_q   <= 1'b0;
         for (int unsigned i = 0; i < IfMaxInflight; i++) begin
            trk_pc_q[i] <= '0;
            trk_ep_q[i] <= 1'b0;
         end
         trk_wr_q  <= 1'b0;
         trk_rd_q  <= 1'b0;
         trk_cnt_q <= '0;
      end else begin
         pc_q      <= pc_d;
         epoch_q   <= epoch_d;
         trk_pc_q  <= trk_pc_d;
         trk_ep_q  <= trk_ep_d;
         trk_wr_q  <= trk_wr_d;
         trk_rd_q  <= trk_rd_d;
         trk_cnt_q <= trk_cnt_d;
      end
   end

   fetch_queue u_fetch_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (rsp_live),
      .push_data (push_data),
      .pop       (q_pop),
      .head      (q_head),
      .full      (q_full),
      .empty     (q_empty),
      .count     (q_cnt)
   );

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: in-order memory model plus a stream-level reference of
// the instruction sequence decode should see.
module tb_stage_if;
   import rvcpu::*;

   localparam pc_t RST_PC = 32'h8000_0000;

   logic      clk = 1'b0;
   logic      rst;
   logic      imem_req_valid;
   logic      imem_req_ready;
   pc_t       imem_req_addr;
   logic      imem_rsp_valid;
   opcode_t   imem_rsp_data;
   logic      imem_rsp_err;
   logic      redirect_valid;
   pc_t       redirect_pc;
   logic      stall;
   logic      out_valid;
   stage_if_t out;

   stage_if #(.ResetPC(RST_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .out_valid      (out_valid),
      .out            (out)
   );

   always #5 clk = ~clk;

   typedef struct {
      pc_t         addr;
      int unsigned due;
   } mreq_t;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cyc   = 0;
   int unsigned lat   = 1;
   int unsigned delivered = 0;
   mreq_t       mq[$];
   pc_t         err_addr = 32'h0000_0001;
   bit          rand_err = 1'b0;
   pc_t         exp_pc, exp_req;
   bit          prev_hold = 1'b0;
   stage_if_t   prev_out;

   function automatic opcode_t mem_word(input pc_t a);
      return a ^ {a[15:0], a[31:16]} ^ 32'h1234_5678;
   endfunction

   function automatic bit mem_err(input pc_t a);
      return (a == err_addr) || (rand_err && (a[6:2] == 5'd19));
   endfunction

   function automatic stage_if_t exp_word(input pc_t a);
      stage_if_t e;
      e.pc     = a;
      e.fault  = mem_err(a);
      e.opcode = e.fault ? NopOpcode : mem_word(a);
      return e;
   endfunction

   // Memory drives its response for this cycle, then outputs settle.
   task automatic step_begin();
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mq[0].addr);
         imem_rsp_err   = mem_err(mq[0].addr);
         void'(mq.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom();
         imem_rsp_err   = 1'($urandom_range(0, 1));
      end
      #1;
   endtask

   // Reference-model bookkeeping for this cycle, then advance the clock.
   task automatic step_end();
      stage_if_t e;
      if (rst) begin
         exp_pc    = RST_PC;
         exp_req   = RST_PC;
         prev_hold = 1'b0;
      end else begin
         total++;
         if (imem_req_addr[1:0] !== 2'b00) begin
            bad++; $display("FAIL addr_align: got %h want low bits 00", imem_req_addr);
         end
         if (redirect_valid) begin
            total++;
            if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
               bad++; $display("FAIL redirect_quiet: got req_valid=%b out_valid=%b want 0 0",
                               imem_req_valid, out_valid);
            end
         end
         if (prev_hold && !redirect_valid) begin
            total++;
            if (out_valid !== 1'b1 || out !== prev_out) begin
               bad++; $display("FAIL stall_hold: got v=%b out=%h want v=1 out=%h",
                               out_valid, out, prev_out);
            end
         end
         if (imem_req_valid && imem_req_ready) begin
            total++;
            if (imem_req_addr !== exp_req) begin
               bad++; $display("FAIL req_addr: got %h want %h", imem_req_addr, exp_req);
            end
            exp_req = exp_req + 32'd4;
            mq.push_back('{imem_req_addr, cyc + lat});
            total++;
            if (mq.size() > 2) begin
               bad++; $display("FAIL inflight: got %0d want <=2", mq.size());
            end
         end
         if (out_valid && !stall) begin
            e = exp_word(exp_pc);
            total++;
            if (out !== e) begin
               bad++; $display("FAIL out_word: got %h want %h", out, e);
            end
            exp_pc = exp_pc + 32'd4;
            delivered++;
         end
         prev_hold = out_valid && stall;
         prev_out  = out;
         if (redirect_valid) begin
            exp_pc  = redirect_pc & ~pc_t'(3);
            exp_req = exp_pc;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input int unsigned n);
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      stall          = 1'b0;
      imem_req_ready = 1'b1;
      repeat (n) begin
         step_begin();
         step_end();
      end
      rst = 1'b0;
      mq.delete();
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      stall          = 1'b0;
      imem_req_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step_begin();
         total++;
         if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || out !== '0) begin
            bad++; $display("FAIL reset_outputs: got req=%b ov=%b out=%h want 0 0 0",
                            imem_req_valid, out_valid, out);
         end
         step_end();
      end
      rst = 1'b0;
      mq.delete();
   endtask

   task automatic test_stream();
      do_reset(2);
      lat = 1;
      for (int k = 0; k < 12; k++) begin
         step_begin();
         total++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC + 32'(4 * k)) begin
            bad++; $display("FAIL stream_req[%0d]: got v=%b a=%h want v=1 a=%h",
                            k, imem_req_valid, imem_req_addr, RST_PC + 32'(4 * k));
         end
         total++;
         if (out_valid !== (k >= 2)) begin
            bad++; $display("FAIL stream_valid[%0d]: got %b want %b", k, out_valid, k >= 2);
         end
         if (k >= 2) begin
            total++;
            if (out.pc !== RST_PC + 32'(4 * (k - 2))) begin
               bad++; $display("FAIL stream_pc[%0d]: got %h want %h",
                               k, out.pc, RST_PC + 32'(4 * (k - 2)));
            end
         end
         step_end();
      end
   endtask

   task automatic test_stall();
      stage_if_t held;
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step_begin();
         if (i == 0) held = out;
         total++;
         if (out_valid !== 1'b1 || out !== held) begin
            bad++; $display("FAIL stall_out[%0d]: got v=%b %h want v=1 %h", i, out_valid, out, held);
         end
         if (i >= 1) begin
            total++;
            if (imem_req_valid !== 1'b0) begin
               bad++; $display("FAIL stall_req[%0d]: got %b want 0", i, imem_req_valid);
            end
         end
         step_end();
      end
      stall = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step_begin();
         total++;
         if (out_valid !== 1'b1 || out.pc !== held.pc + 32'(4 * i)) begin
            bad++; $display("FAIL stall_resume[%0d]: got v=%b pc=%h want v=1 pc=%h",
                            i, out_valid, out.pc, held.pc + 32'(4 * i));
         end
         step_end();
      end
   endtask

   task automatic test_redirect();
      bit found = 1'b0;
      bit seen  = 1'b0;
      do_reset(2);
      lat = 2;
      for (int i = 0; i < 20 && !found; i++) begin
         if (mq.size() == 2) found = 1'b1;
         else begin step_begin(); step_end(); end
      end
      total++;
      if (!found) begin
         bad++; $display("FAIL redir_setup: got no 2-in-flight point want one within 20 cycles");
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0100;
      step_begin();
      total++;
      if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
         bad++; $display("FAIL redir_cycle: got ov=%b req=%b want 0 0", out_valid, imem_req_valid);
      end
      step_end();
      redirect_valid = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step_begin();
         if (out_valid) begin
            seen = 1'b1;
            total++;
            if (out.pc !== 32'h8000_0100) begin
               bad++; $display("FAIL redir_first: got %h want 80000100", out.pc);
            end
         end
         step_end();
      end
      total++;
      if (!seen) begin
         bad++; $display("FAIL redir_timeout: got no out_valid want one within 20 cycles");
      end
      lat = 1;
   endtask

   task automatic test_fault();
      bit seen = 1'b0;
      err_addr = 32'h8000_0008;
      do_reset(2);
      lat = 1;
      for (int i = 0; i < 12 && !seen; i++) begin
         step_begin();
         if (out_valid && out.pc == 32'h8000_0008) begin
            seen = 1'b1;
            total++;
            if (out.fault !== 1'b1 || out.opcode !== 32'h0000_0013) begin
               bad++; $display("FAIL fault_word: got fault=%b op=%h want 1 00000013",
                               out.fault, out.opcode);
            end
         end
         step_end();
      end
      total++;
      if (!seen) begin
         bad++; $display("FAIL fault_timeout: got no word at 80000008 want one within 12 cycles");
      end
      err_addr = 32'h0000_0001;
   endtask

   task automatic test_ready_redirect();
      bit seen = 1'b0;
      do_reset(2);
      lat = 1;
      repeat (4) begin step_begin(); step_end(); end
      imem_req_ready = 1'b0;
      stall          = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step_begin();
         total++;
         if (out_valid !== 1'b1) begin
            bad++; $display("FAIL nrdy_hold[%0d]: got %b want 1", i, out_valid);
         end
         step_end();
      end
      imem_req_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0203;
      step_begin();
      total++;
      if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
         bad++; $display("FAIL rs_cycle: got ov=%b req=%b want 0 0", out_valid, imem_req_valid);
      end
      step_end();
      redirect_valid = 1'b0;
      stall          = 1'b0;
      step_begin();
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200 || out_valid !== 1'b0) begin
         bad++; $display("FAIL rs_next: got req=%b a=%h ov=%b want 1 80000200 0",
                         imem_req_valid, imem_req_addr, out_valid);
      end
      step_end();
      for (int i = 0; i < 10 && !seen; i++) begin
         step_begin();
         if (out_valid) begin
            seen = 1'b1;
            total++;
            if (out.pc !== 32'h8000_0200) begin
               bad++; $display("FAIL rs_first: got %h want 80000200", out.pc);
            end
         end
         step_end();
      end
      total++;
      if (!seen) begin
         bad++; $display("FAIL rs_timeout: got no out_valid want one within 10 cycles");
      end
   endtask

   task automatic test_reset_midstream();
      bit seen = 1'b0;
      do_reset(2);
      lat = 2;
      repeat (7) begin step_begin(); step_end(); end
      total++;
      if (mq.size() == 0) begin
         bad++; $display("FAIL mid_setup: got 0 pending want >0");
      end
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step_begin();
         total++;
         if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || out !== '0) begin
            bad++; $display("FAIL mid_rst[%0d]: got req=%b ov=%b out=%h want 0 0 0",
                            i, imem_req_valid, out_valid, out);
         end
         step_end();
      end
      rst = 1'b0;
      mq.delete();
      step_begin();
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
         bad++; $display("FAIL mid_first_req: got v=%b a=%h want 1 %h",
                         imem_req_valid, imem_req_addr, RST_PC);
      end
      step_end();
      for (int i = 0; i < 10 && !seen; i++) begin
         step_begin();
         if (out_valid) begin
            seen = 1'b1;
            total++;
            if (out !== exp_word(RST_PC)) begin
               bad++; $display("FAIL mid_first_out: got %h want %h", out, exp_word(RST_PC));
            end
         end
         step_end();
      end
      total++;
      if (!seen) begin
         bad++; $display("FAIL mid_timeout: got no out_valid want one within 10 cycles");
      end
      lat = 1;
   endtask

   task automatic test_random();
      int unsigned start_cnt;
      pc_t         off;
      rand_err = 1'b1;
      do_reset(2);
      start_cnt = delivered;
      for (int i = 0; i < 1500; i++) begin
         if (i % 200 == 0 && mq.size() == 0) lat = $urandom_range(1, 3);
         imem_req_ready = ($urandom_range(0, 99) < 70);
         stall          = ($urandom_range(0, 99) < 30);
         redirect_valid = ($urandom_range(0, 99) < 4);
         off            = pc_t'($urandom_range(0, 4095));
         redirect_pc    = 32'h8000_0000 + off;
         step_begin();
         step_end();
      end
      redirect_valid = 1'b0;
      stall          = 1'b0;
      total++;
      if (delivered - start_cnt < 100) begin
         bad++; $display("FAIL rand_progress: got %0d words want >=100", delivered - start_cnt);
      end
      rand_err = 1'b0;
      lat      = 1;
   endtask

   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_fault();
      test_ready_redirect();
      test_reset_midstream();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion want finish before 2ms");
      $fatal(1, "watchdog expired");
   end

endmodule
